// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The optional FETCH_PERF_CNT_EN macro is consumed by inst_fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DROP
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

    // Entry layout for the default 32-bit configuration; the FIFO takes the
    // entry type as a parameter so wider/narrower builds stay consistent.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop/flush, head presented combinationally
// from the storage registers and forced to zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fifo_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count < CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because head is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one-outstanding word
// fetches over req/gnt/rvalid and buffers results for decode.
// Optional: define FETCH_PERF_CNT_EN to add the stall_cnt output.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] req_pc;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop_eff;
    entry_t            push_data;
    entry_t            head;

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign pop_eff    = inst_valid && inst_ready && !redirect_valid;
    assign push       = (state == RESP) && imem_rvalid && !redirect_valid;
    assign push_data  = '{inst: imem_rdata, pc: req_pc};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_eff),
        .flush     (redirect_val_q_unused_guard()),
        .head      (head),
        .count     (count)
    );

    function automatic logic redirect_val_q_unused_guard();
        return redirect_valid;
    endfunction

    // State, fetch PC and in-flight request PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if ((state == REQ) && imem_gnt) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // Next-state and PC selection; a redirect overrides the normal flow and
    // retargets fetch_pc, choosing DROP whenever a response is still owed.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        imem_req     = 1'b0;
        case (state)
            IDLE: begin
                if (count < CW'(DEPTH)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    fetch_pc_nxt = fetch_pc + ADDR_W'(PC_STEP);
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    state_nxt = ((count + CW'(1) - CW'(pop_eff)) < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & ~ADDR_W'(3);
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = imem_gnt ? DROP : REQ;
                RESP:    state_nxt = imem_rvalid ? REQ : DROP;
                DROP:    state_nxt = imem_rvalid ? REQ : DROP;
                default: state_nxt = REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts cycles where decode is waiting on an empty buffer; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (inst_ready && !inst_valid && !redirect_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
